wb_master_port: RTL
===================

Name: wb_master_port

Overview:
- Single-outstanding Wishbone classic initiator. It is the other end of the user-project Wishbone slave interface.
- Converts a valid/ready command stream into one Wishbone read or write cycle per command, and returns a valid/ready response stream.
- Used by on-chip engines (UART loader, test sequencer) to drive Wishbone slaves inside the user project.
- Clocked on wb_clk_i.

Parameters:
- ADDR_W, 32, address width of command and bus.
- DATA_W, 32, data width; must be 32.
- SEL_W, 4, byte-select width, DATA_W/8.
- TIMEOUT_CYCLES, 255, cycles in BUS without ack before abort. Used only with WBM_TIMEOUT_EN; must be ≥ 1.

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid is also high
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  ADDR_W  byte address
- cmd_dat  input  DATA_W  write data
- cmd_sel  input  SEL_W  byte enables
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_dat  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  command failed
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  SEL_W  Wishbone byte select
- wbm_adr_o  output  ADDR_W  Wishbone address
- wbm_dat_o  output  DATA_W  Wishbone write data
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_dat_i  input  DATA_W  Wishbone read data
- busy  output  1  state != IDLE

Behaviour:
- Interface is decided: one clock, wb_clk_i; reset wb_rst_i, synchronous and active-high.
- All outputs are registered except cmd_ready and busy, which decode state.
- Reset values: wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0. State = IDLE.
- State machine, three states:
  - IDLE: cmd_ready=1.
    - On cmd_valid, latch we, sel, dat, and adr with adr[1:0] forced to 2'b00.
    - If cmd_sel==0: go to RESP with rsp_err=1, rsp_dat=0. No bus cycle is issued.
    - Otherwise: go to BUS, and assert cyc=stb=1 on the next edge.
  - BUS: cyc, stb, we, sel, adr, dat held stable.
    - The edge that samples wbm_ack_i=1 does all of the following: clears cyc and stb, loads rsp_dat (wbm_dat_i for a read, 0 for a write), sets rsp_err=0 and rsp_valid=1, and moves to RESP.
  - RESP: rsp_valid=1 and the response is held stable until rsp_ready.
    - On rsp_ready: rsp_valid=0, go to IDLE. cmd_ready rises in the following cycle.
- Latency, zero-wait slave (ack in the first stb cycle):
  - accept at edge 0, cyc/stb high after edge 0;
  - ack sampled at edge 1, rsp_valid high after edge 1;
  - next command accepted no earlier than one cycle after rsp handshake.
  - Throughput is at most 1 command per 3 cycles.
- wbm_ack_i while not in BUS is ignored, and no state changes.
- Bus outputs other than cyc/stb retain their last values after the cycle ends; they are don't-care when cyc=0.
- Reset asserted mid-operation, in any state: all outputs return to reset values on that edge. Any in-flight bus cycle is dropped (cyc low). Any pending response is discarded.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- With the macro defined:
  - an 8..16-bit counter clears on entry to BUS and increments each BUS cycle without ack;
  - when it reaches TIMEOUT_CYCLES with ack still low: cyc/stb are cleared, and the response is rsp_err=1, rsp_dat=0, go to RESP.
  - Ack in the same cycle as the limit wins, giving a normal response.
- Without the macro: no counter logic, and BUS waits indefinitely for ack. rsp_err is set only by sel==0.

Decomposition:
- Package wbm_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - localparams for data width 32, sel width 4, and error read value 32'h0.
- No sub-module. The optional timeout counter is inline under the macro guard.

Test Plan:
- Write:
  - Stimulus: cmd we=1, adr=32'h3000_0007, dat=32'hA5A5_1234, sel=4'hF; slave acks after 2 wait cycles.
  - Response: wbm_adr_o=32'h3000_0004; cyc/stb high exactly 3 cycles; rsp_valid with rsp_err=0, rsp_dat=0.
- Read, zero-wait:
  - Stimulus: cmd we=0, adr=32'h3000_0010, sel=4'hF; slave drives 32'hDEAD_BEEF with ack in the first stb cycle.
  - Response: rsp_valid after edge 1; rsp_dat=32'hDEAD_BEEF.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after a read; cmd_valid held high with a second command.
  - Response: rsp stable for 10 cycles; cmd_ready=0 throughout; second command accepted the cycle after the rsp handshake.
- Zero select:
  - Stimulus: cmd sel=4'h0.
  - Response: cyc never asserted; rsp_err=1, rsp_dat=0 after 1 cycle.
- Timeout, WBM_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - Stimulus: slave never acks.
  - Response: cyc drops after 8 BUS cycles; rsp_err=1.
  - Without the macro: cyc stays high for 1000 cycles.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i for 1 cycle during BUS; a stray ack arrives afterwards.
  - Response: cyc/stb=0 on the next edge; rsp_valid stays 0; stray ack ignored; cmd_ready=1.

Source files
------------

// File: rtl/wbm_pkg.sv
// Shared types and constants for the single-outstanding Wishbone classic initiator.
package wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

  localparam int WBM_DATA_W = 32;
  localparam int WBM_SEL_W  = 4;
  localparam int WBM_CNT_W  = 16;
  localparam logic [WBM_DATA_W-1:0] WBM_ERR_RDATA = 32'h0;

endpackage

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one bus cycle per command, one response per command.
// Optional ack timeout is enabled by defining WBM_TIMEOUT_EN.
module wb_master_port
  import wbm_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = WBM_DATA_W,
  parameter int SEL_W          = WBM_SEL_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1 || DATA_W != 32 || SEL_W != DATA_W / 8) begin : g_param_check
    $error("wb_master_port: unsupported parameter combination");
  end

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // valid and its payload stay stable until that edge, and ready never waits on valid.
  wbm_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef WBM_TIMEOUT_EN
  logic [WBM_CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
`ifdef WBM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d  = cmd_we;
          sel_d = cmd_sel;
          dat_d = cmd_dat;
          adr_d = cmd_adr & ~ADDR_W'(2'b11);
          if (cmd_sel == '0) begin
            // Nothing to transfer: fail the command without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = WBM_ERR_RDATA;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
`ifdef WBM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
        end
`ifdef WBM_TIMEOUT_EN
        else if (cnt_q == WBM_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = WBM_ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
`ifdef WBM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule
